// File: rtl/canvas_capture_if.sv
// -----------------------------------------------------------------------------
// canvas_capture_if
// Groups the paint controls and the bit-stream handshake of canvas_capture.
//   paint/col/row : paint strobe and 4-bit grid address (valid 0..13)
//   clear         : erase the live bitmap
//   start         : request a snapshot stream
//   bit_ready     : downstream accepts bit_data this cycle
//   bit_data/bit_valid/bit_last : streamed cell value, qualifier, final-bit flag
//   busy          : stream in progress
//   pixel_count   : number of set cells in the live bitmap (0..196)
// master = the side driving paint/stream requests, slave = canvas_capture.
// -----------------------------------------------------------------------------
interface canvas_capture_if;
  logic       paint;
  logic [3:0] col;
  logic [3:0] row;
  logic       clear;
  logic       start;
  logic       bit_ready;
  logic       bit_data;
  logic       bit_valid;
  logic       bit_last;
  logic       busy;
  logic [7:0] pixel_count;

  modport master (
    output paint, col, row, clear, start, bit_ready,
    input  bit_data, bit_valid, bit_last, busy, pixel_count
  );

  modport slave (
    input  paint, col, row, clear, start, bit_ready,
    output bit_data, bit_valid, bit_last, busy, pixel_count
  );
endinterface

// File: rtl/canvas_capture.sv
// -----------------------------------------------------------------------------
// canvas_capture
// Holds a 14x14 live bitmap painted one cell at a time, tracks how many cells
// are set, and on request streams a frozen snapshot out one bit per transfer
// (row-major, index = row*14 + col) over a valid/ready handshake.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   reset    : synchronous, active-high reset
//   bus      : canvas_capture_if.slave (paint controls + bit stream)
// Build option:
//   CANVAS_DILATE_EN - a paint also sets the in-grid 4-neighbours of the cell.
// -----------------------------------------------------------------------------
module canvas_capture (
  input  logic              CLOCK_50,
  input  logic              reset,
  canvas_capture_if.slave   bus
);
  localparam int unsigned CELLS    = 196;
  localparam logic [7:0]  LAST_IDX = 8'd195;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state_q, state_d;
  logic [CELLS-1:0] live_q, live_d;
  logic [CELLS-1:0] snap_q, snap_d;
  logic [7:0]       index_q, index_d;
  logic [7:0]       pixel_count_q, pixel_count_d;

  logic             in_range;
  logic [7:0]       cell_idx;
  logic [CELLS-1:0] paint_mask;
  logic [2:0]       add_count;
  logic             bit_data, bit_valid, bit_last, busy;

  assign in_range = bus.paint && (bus.col < 4'd14) && (bus.row < 4'd14);
  assign cell_idx = {4'd0, bus.row} * 8'd14 + {4'd0, bus.col};

  // Cells touched by this paint, and how many of them are newly set. Only
  // the (at most five) addressed cells are tested, so no wide popcount.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    paint_mask = '0;
    add_count  = 3'd0;
    if (in_range) begin
      paint_mask[cell_idx] = 1'b1;
      if (!live_q[cell_idx]) add_count = add_count + 3'd1;
`ifdef CANVAS_DILATE_EN
      // Neighbours clipped at the grid edge; no wrap to the adjacent row.
      if (bus.col != 4'd0) begin
        paint_mask[cell_idx - 8'd1] = 1'b1;
        if (!live_q[cell_idx - 8'd1]) add_count = add_count + 3'd1;
      end
      if (bus.col != 4'd13) begin
        paint_mask[cell_idx + 8'd1] = 1'b1;
        if (!live_q[cell_idx + 8'd1]) add_count = add_count + 3'd1;
      end
      if (bus.row != 4'd0) begin
        paint_mask[cell_idx - 8'd14] = 1'b1;
        if (!live_q[cell_idx - 8'd14]) add_count = add_count + 3'd1;
      end
      if (bus.row != 4'd13) begin
        paint_mask[cell_idx + 8'd14] = 1'b1;
        if (!live_q[cell_idx + 8'd14]) add_count = add_count + 3'd1;
      end
`endif
    end
  end

  // Live bitmap: clear has priority over a same-cycle paint.
  always_comb begin
    if (bus.clear) begin
      live_d        = '0;
      pixel_count_d = 8'd0;
    end else begin
      live_d        = live_q | paint_mask;
      pixel_count_d = pixel_count_q + {5'd0, add_count};
    end
  end

  // Stream FSM: snapshot is frozen at start so painting cannot disturb it.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    index_d   = index_q;
    bit_data  = 1'b0;
    bit_valid = 1'b0;
    bit_last  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_d  = live_q;
          index_d = 8'd0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        busy      = 1'b1;
        bit_valid = 1'b1;
        bit_data  = snap_q[index_q];
        bit_last  = (index_q == LAST_IDX);
        if (bus.bit_ready) begin
          if (index_q == LAST_IDX) state_d = IDLE;
          else                     index_d = index_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      // NOTE: the snapshot is a flop array, not a RAM, so it can and must be reset with the rest.
      state_q       <= IDLE;
      live_q        <= '0;
      snap_q        <= '0;
      index_q       <= 8'd0;
      pixel_count_q <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      live_q        <= live_d;
      snap_q        <= snap_d;
      index_q       <= index_d;
      pixel_count_q <= pixel_count_d;
    end
  end

  assign bus.bit_data    = bit_data;
  assign bus.bit_valid   = bit_valid;
  assign bus.bit_last    = bit_last;
  assign bus.busy        = busy;
  assign bus.pixel_count = pixel_count_q;
endmodule
